// File: rtl/tb_obi_multiport_mem_if.sv
// OBI request/response bundle for NUM_PORTS channels; directions named from the memory side.
// Responses carry no backpressure: rvalid is a one-cycle pulse.
interface tb_obi_multiport_mem_if #(
  parameter int NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0]       req_i;
  logic [NUM_PORTS-1:0][31:0] addr_i;
  logic [NUM_PORTS-1:0]       we_i;
  logic [NUM_PORTS-1:0][3:0]  be_i;
  logic [NUM_PORTS-1:0][31:0] wdata_i;
  logic [NUM_PORTS-1:0]       gnt_o;
  logic [NUM_PORTS-1:0]       rvalid_o;
  logic [NUM_PORTS-1:0][31:0] rdata_o;

  modport master (output req_i, addr_i, we_i, be_i, wdata_i, input gnt_o, rvalid_o, rdata_o);
  modport slave  (input req_i, addr_i, we_i, be_i, wdata_i, output gnt_o, rvalid_o, rdata_o);
endinterface

// File: rtl/tb_obi_multiport_mem.sv
// Shared word RAM behind NUM_PORTS OBI channels; fixed RESP_LATENCY cycles grant-to-rvalid.
// Grants throttle on per-port outstanding limit and optional LFSR stalls; rvalid is never backpressured.
module tb_obi_multiport_mem #(
  parameter int          NUM_PORTS       = 2,
  parameter int          RAM_ADDR_WIDTH  = 20,
  parameter int          RESP_LATENCY    = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          STALL_MODE      = 0,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter logic [31:0] STATUS_ADDR     = 32'h2000_0000,
  parameter logic [31:0] EXIT_ADDR       = 32'h2000_0004
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  tb_obi_multiport_mem_if.slave        bus,
  output logic                         tests_passed_o,
  output logic                         tests_failed_o,
  output logic                         exit_valid_o,
  output logic [31:0]                  exit_value_o
);
  localparam int          IW        = RAM_ADDR_WIDTH - 2;
  localparam int          WORDS     = 2 ** IW;
  localparam logic [3:0]  MAX_CNT   = 4'(MAX_OUTSTANDING);
  localparam logic [31:0] PASS_CODE = 32'd123456789;

  logic [31:0]             mem_q   [WORDS];
  logic [15:0]             lfsr_q  [NUM_PORTS];
  logic [15:0]             lfsr_d  [NUM_PORTS];
  logic [3:0]              cnt_q   [NUM_PORTS];
  logic [3:0]              cnt_d   [NUM_PORTS];
  logic [RESP_LATENCY-1:0] vld_q   [NUM_PORTS];
  logic [RESP_LATENCY-1:0] vld_d   [NUM_PORTS];
  logic [31:0]             dat_q   [NUM_PORTS][RESP_LATENCY];
  logic [31:0]             dat_d   [NUM_PORTS][RESP_LATENCY];
  logic                    passed_q, passed_d, failed_q, failed_d, exit_vld_q, exit_vld_d;
  logic [31:0]             exit_val_q, exit_val_d;

  logic [NUM_PORTS-1:0]    fire, retire, is_ram;
  logic [IW-1:0]           idx     [NUM_PORTS];
  logic [31:0]             rd_word [NUM_PORTS];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      idx[p]     = bus.addr_i[p][RAM_ADDR_WIDTH-1:2];
      is_ram[p]  = (bus.addr_i[p] >> RAM_ADDR_WIDTH) == 32'd0;
      retire[p]  = vld_q[p][RESP_LATENCY-1];
      fire[p]    = rst_ni && bus.req_i[p] && ((cnt_q[p] < MAX_CNT) || retire[p])
                   && !((STALL_MODE == 1) && (lfsr_q[p][1:0] == 2'b00));
      // Read data is taken before this edge's writes land, so same-cycle reads see old contents.
      rd_word[p] = (is_ram[p] && !bus.we_i[p]) ? mem_q[idx[p]] : 32'd0;
    end
  end

  always_comb begin
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    vld_d      = vld_q;
    dat_d      = dat_q;
    passed_d   = passed_q;
    failed_d   = failed_q;
    exit_vld_d = exit_vld_q;
    exit_val_d = exit_val_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      lfsr_d[p] = {lfsr_q[p][14:0], lfsr_q[p][15] ^ lfsr_q[p][13] ^ lfsr_q[p][12] ^ lfsr_q[p][10]};
      if (fire[p] && !retire[p])      cnt_d[p] = cnt_q[p] + 4'd1;
      else if (!fire[p] && retire[p]) cnt_d[p] = cnt_q[p] - 4'd1;
      vld_d[p]    = vld_q[p] << 1;
      vld_d[p][0] = fire[p];
      // Data only moves with a valid token, so the output stage holds its last response.
      for (int i = RESP_LATENCY - 1; i > 0; i--) begin
        if (vld_q[p][i-1]) dat_d[p][i] = dat_q[p][i-1];
      end
      if (fire[p]) dat_d[p][0] = rd_word[p];
      if (fire[p] && bus.we_i[p]) begin
        if (bus.addr_i[p] == STATUS_ADDR) begin
          if (bus.wdata_i[p] == PASS_CODE)  passed_d = 1'b1;
          else if (bus.wdata_i[p] == 32'd1) failed_d = 1'b1;
        end
        if (bus.addr_i[p] == EXIT_ADDR) begin
          exit_vld_d = 1'b1;
          exit_val_d = bus.wdata_i[p];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        lfsr_q[p] <= LFSR_SEED ^ 16'(p);
        cnt_q[p]  <= 4'd0;
        vld_q[p]  <= '0;
        for (int i = 0; i < RESP_LATENCY; i++) dat_q[p][i] <= 32'd0;
      end
      passed_q   <= 1'b0;
      failed_q   <= 1'b0;
      exit_vld_q <= 1'b0;
      exit_val_q <= 32'd0;
    end else begin
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      vld_q      <= vld_d;
      dat_q      <= dat_d;
      passed_q   <= passed_d;
      failed_q   <= failed_d;
      exit_vld_q <= exit_vld_d;
      exit_val_q <= exit_val_d;
    end
  end

  // Ascending port order lets the highest-index writer win each byte lane.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int b = 0; b < 4; b++) begin
        if (fire[p] && bus.we_i[p] && is_ram[p] && bus.be_i[p][b])
          mem_q[idx[p]][8*b +: 8] <= bus.wdata_i[p][8*b +: 8];
      end
    end
  end

  always_comb begin
    bus.gnt_o = fire;
    for (int p = 0; p < NUM_PORTS; p++) begin
      bus.rvalid_o[p] = vld_q[p][RESP_LATENCY-1];
      bus.rdata_o[p]  = dat_q[p][RESP_LATENCY-1];
    end
  end

  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = exit_vld_q;
  assign exit_value_o   = exit_val_q;
endmodule

// File: tb/tb_tb_obi_multiport_mem.sv
// Bench: instance A (3 ports, latency 4, limit 2) for data paths and peripherals,
// instance B (1 port, latency 1, random stalls) for the grant-stall pattern.
module tb_tb_obi_multiport_mem;
  localparam logic [31:0] ST = 32'h2000_0000;
  localparam logic [31:0] EX = 32'h2000_0004;
  localparam logic [31:0] NX = 32'h3000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_na, rst_nb;
  int   checks = 0, failures = 0, cyc = 0;

  typedef struct { logic [31:0] d; int c; } exp_t;
  exp_t qa [3][$];
  exp_t qb [$];

  logic        pa, fa, eva, pb, fb, evb;
  logic [31:0] exa, exb;

  tb_obi_multiport_mem_if #(.NUM_PORTS(3)) bus_a ();
  tb_obi_multiport_mem_if #(.NUM_PORTS(1)) bus_b ();

  tb_obi_multiport_mem #(.NUM_PORTS(3), .RAM_ADDR_WIDTH(16), .RESP_LATENCY(4),
                         .MAX_OUTSTANDING(2), .STALL_MODE(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_na), .bus(bus_a),
    .tests_passed_o(pa), .tests_failed_o(fa), .exit_valid_o(eva), .exit_value_o(exa));

  tb_obi_multiport_mem #(.NUM_PORTS(1), .RAM_ADDR_WIDTH(16), .RESP_LATENCY(1),
                         .MAX_OUTSTANDING(2), .STALL_MODE(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_nb), .bus(bus_b),
    .tests_passed_o(pb), .tests_failed_o(fb), .exit_valid_o(evb), .exit_value_o(exb));

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Monitor: every rvalid pops the oldest expectation of that port.
  always @(negedge clk) begin
    exp_t e;
    for (int p = 0; p < 3; p++) begin
      if (bus_a.rvalid_o[p] === 1'b1) begin
        if (qa[p].size() == 0) chk($sformatf("a%0d_unexpected_rvalid", p), bus_a.rvalid_o[p], 0);
        else begin
          e = qa[p].pop_front();
          chk($sformatf("a%0d_rdata", p), bus_a.rdata_o[p], e.d);
          chk($sformatf("a%0d_latency_cycle", p), cyc, e.c);
        end
      end
    end
    if (bus_b.rvalid_o[0] === 1'b1) begin
      if (qb.size() == 0) chk("b_unexpected_rvalid", bus_b.rvalid_o[0], 0);
      else begin
        e = qb.pop_front();
        chk("b_rdata", bus_b.rdata_o[0], e.d);
        chk("b_latency_cycle", cyc, e.c);
      end
    end
  end

  task automatic set_a(input int p, input logic we, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    bus_a.req_i[p]   = 1'b1;
    bus_a.we_i[p]    = we;
    bus_a.addr_i[p]  = a;
    bus_a.be_i[p]    = be;
    bus_a.wdata_i[p] = wd;
  endtask

  task automatic fire_a(input logic [2:0] m, input logic [31:0] e0, e1, e2);
    int          n = 0;
    logic [31:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    @(negedge clk);
    while ((bus_a.gnt_o & m) != m && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("a_grant_timeout", bus_a.gnt_o & m, m);
    else for (int p = 0; p < 3; p++) if (m[p]) qa[p].push_back('{d: e[p], c: cyc + 4});
    @(posedge clk); #1;
    bus_a.req_i = bus_a.req_i & ~m;
  endtask

  task automatic drain_a();
    int n = 0;
    while ((qa[0].size() + qa[1].size() + qa[2].size()) != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) chk("a_drain_timeout", qa[0].size() + qa[1].size() + qa[2].size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wr_a(input int p, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    set_a(p, 1'b1, a, be, wd);
    fire_a(3'(1 << p), 32'd0, 32'd0, 32'd0);
    drain_a();
  endtask

  task automatic rd_a(input int p, input logic [31:0] a, input logic [31:0] exp);
    set_a(p, 1'b0, a, 4'hF, 32'd0);
    fire_a(3'(1 << p), exp, exp, exp);
    drain_a();
  endtask

  task automatic drain_b();
    int n = 0;
    while (qb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("b_drain_timeout", qb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  got;
    logic [2:0]  acc;
    logic [15:0] m;
    int          n, mn, mism;

    bus_a.req_i = '0; bus_a.we_i = '0; bus_a.addr_i = '0; bus_a.be_i = '0; bus_a.wdata_i = '0;
    bus_b.req_i = '0; bus_b.we_i = '0; bus_b.addr_i = '0; bus_b.be_i = '0; bus_b.wdata_i = '0;
    rst_na = 1'b0; rst_nb = 1'b0;

    // Requests held during reset must not be granted.
    bus_a.req_i = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", bus_a.gnt_o, 0);
    chk("rst_rvalid", bus_a.rvalid_o, 0);
    chk("rst_rdata", bus_a.rdata_o, 0);
    chk("rst_flags", {pa, fa, eva}, 0);
    chk("rst_exit_value", exa, 0);
    bus_a.req_i = '0;
    @(posedge clk); #1;
    rst_na = 1'b1; rst_nb = 1'b1;
    @(posedge clk); #1;

    // Basic write/read and ignored low address bits.
    wr_a(0, 32'h100, 4'hF, 32'hDEADBEEF);
    rd_a(0, 32'h100, 32'hDEADBEEF);
    rd_a(1, 32'h102, 32'hDEADBEEF);

    // Byte enables.
    wr_a(0, 32'h104, 4'hF, 32'h11223344);
    wr_a(0, 32'h104, 4'b0101, 32'hAABBCCDD);
    rd_a(2, 32'h104, 32'h11BB33DD);

    // Same-cycle collisions.
    wr_a(0, 32'h200, 4'hF, 32'h5A5A5A5A);
    set_a(0, 1'b1, 32'h200, 4'hF, 32'h0000_0000);
    set_a(1, 1'b1, 32'h200, 4'hF, 32'hFFFF_FFFF);
    set_a(2, 1'b0, 32'h200, 4'hF, 32'h0);
    fire_a(3'b111, 32'd0, 32'd0, 32'h5A5A5A5A);
    drain_a();
    rd_a(0, 32'h200, 32'hFFFFFFFF);
    set_a(0, 1'b1, 32'h204, 4'hF, 32'h01020304);
    set_a(1, 1'b1, 32'h204, 4'b0011, 32'hAAAAAAAA);
    fire_a(3'b011, 32'd0, 32'd0, 32'd0);
    drain_a();
    rd_a(1, 32'h204, 32'h0102AAAA);

    // Outstanding limit: with limit 2 and latency 4, grants resume on the first retire.
    set_a(1, 1'b0, 32'h100, 4'hF, 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      got[k] = bus_a.gnt_o[1];
      if (bus_a.gnt_o[1]) qa[1].push_back('{d: 32'hDEADBEEF, c: cyc + 4});
      @(posedge clk); #1;
    end
    bus_a.req_i[1] = 1'b0;
    chk("a1_gnt_pattern", got, 6'b110011);
    drain_a();

    // Status and exit registers.
    wr_a(0, ST, 4'hF, 32'd5);
    chk("status_other_value_ignored", {pa, fa}, 2'b00);
    wr_a(1, ST, 4'hF, 32'd123456789);
    chk("status_pass", {pa, fa}, 2'b10);
    wr_a(2, EX, 4'hF, 32'h2A);
    chk("exit_valid", eva, 1);
    chk("exit_value", exa, 32'h2A);
    set_a(0, 1'b1, EX, 4'hF, 32'h11);
    set_a(2, 1'b1, EX, 4'hF, 32'h33);
    fire_a(3'b101, 32'd0, 32'd0, 32'd0);
    chk("exit_collision_value", exa, 32'h33);
    drain_a();
    rd_a(0, NX, 32'd0);
    rd_a(1, ST, 32'd0);
    wr_a(2, ST, 4'hF, 32'd1);
    chk("status_fail_sticky_pass", {pa, fa}, 2'b11);

    // Reset with two reads in flight: responses dropped, RAM kept.
    set_a(0, 1'b0, 32'h100, 4'hF, 32'h0);
    fire_a(3'b001, 32'hDEADBEEF, 32'd0, 32'd0);
    set_a(0, 1'b0, 32'h100, 4'hF, 32'h0);
    fire_a(3'b001, 32'hDEADBEEF, 32'd0, 32'd0);
    rst_na = 1'b0;
    qa[0].delete();
    @(negedge clk);
    chk("midrst_rvalid", bus_a.rvalid_o, 0);
    chk("midrst_flags", {pa, fa, eva}, 0);
    chk("midrst_exit_value", exa, 0);
    @(posedge clk); #1;
    rst_na = 1'b1;
    acc = '0;
    repeat (10) begin @(negedge clk); acc |= bus_a.rvalid_o; end
    chk("no_rvalid_after_reset", acc, 0);
    @(posedge clk); #1;
    rd_a(2, 32'h100, 32'hDEADBEEF);
    rd_a(0, 32'h204, 32'h0102AAAA);

    // Stall mode: 1000 cycles of continuous writes to unmapped space.
    rst_nb = 1'b0;
    @(posedge clk); #1;
    rst_nb = 1'b1;
    @(posedge clk); #1;
    bus_b.req_i = 1'b1; bus_b.we_i = 1'b1; bus_b.addr_i[0] = NX;
    bus_b.be_i[0] = 4'hF; bus_b.wdata_i[0] = 32'h0;
    m = step(16'hACE1);
    n = 0; mn = 0; mism = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (bus_b.gnt_o[0]) begin n++; qb.push_back('{d: 32'd0, c: cyc + 1}); end
      if (m[1:0] != 2'b00) mn++;
      if (bus_b.gnt_o[0] !== (m[1:0] != 2'b00)) mism++;
      m = step(m);
      @(posedge clk); #1;
    end
    bus_b.req_i = 1'b0;
    drain_b();
    chk("b_gnt_cycle_mismatches", mism, 0);
    chk("b_gnt_count_vs_model", n, mn);
    chk("b_gnt_count_in_range", (n >= 700 && n <= 800), 1);
    chk("b_flags_untouched", {pb, fb, evb}, 0);
    chk("b_exit_value", exb, 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tb_obi_multiport_mem.md
Name: tb_obi_multiport_mem

Overview:
Parametrised multi-port OBI memory model for the core testbench subsystem. It replaces the fixed two-channel RAM model and serves NUM_PORTS independent OBI request/response channels (instruction, data, DMA or extra harts) against one shared word array. It adds configurable response latency, a per-port outstanding-transaction limit, optional pseudo-random grant stalls, and memory-mapped test-status and exit registers.

Parameters:
NUM_PORTS, 2, number of OBI channels (1..8)
RAM_ADDR_WIDTH, 20, byte-address width of the RAM region; depth = 2^(RAM_ADDR_WIDTH-2) words
RESP_LATENCY, 1, cycles from grant to rvalid (1..8)
MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions per port (1..8)
STALL_MODE, 0, 0 = grant whenever accepted; 1 = LFSR-driven random grant stalls
LFSR_SEED, 16'hACE1, LFSR seed; port p uses LFSR_SEED ^ p
STATUS_ADDR, 32'h2000_0000, test pass/fail register address
EXIT_ADDR, 32'h2000_0004, exit register address

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  NUM_PORTS  per-port request
addr_i  in  NUM_PORTS*32  per-port byte address
we_i  in  NUM_PORTS  per-port write enable
be_i  in  NUM_PORTS*4  per-port byte enables
wdata_i  in  NUM_PORTS*32  per-port write data
gnt_o  out  NUM_PORTS  per-port grant
rvalid_o  out  NUM_PORTS  per-port response valid
rdata_o  out  NUM_PORTS*32  per-port read data
tests_passed_o  out  1  sticky pass flag
tests_failed_o  out  1  sticky fail flag
exit_valid_o  out  1  sticky exit flag
exit_value_o  out  32  captured exit value

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous and active-low.
- Reset values: rvalid_o=0, rdata_o=0, tests_passed_o=0, tests_failed_o=0, exit_valid_o=0, exit_value_o=0. Outstanding counters are 0, delay lines are empty, and LFSRs are loaded with their seeds. gnt_o is forced to 0 while rst_ni=0.
- Memory array is not reset. The bench preloads it. Contents survive reset.
- Grant rule, per port p, combinational: gnt_o[p] = req_i[p] && (cnt[p] < MAX_OUTSTANDING || retire[p]) && !stall[p].
  - retire[p] is 1 when the last delay-line stage is valid this cycle.
  - stall[p] = (STALL_MODE==1) && (lfsr[p][1:0]==2'b00).
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle out of reset, regardless of req.
- Transaction execution (a transaction is a req && gnt cycle):
  - Read: the word at addr[RAM_ADDR_WIDTH-1:2] is sampled on the grant edge and enters stage 0 of the port's delay line.
  - Write: the bytes selected by be are written on the grant edge. A write also enters the delay line, with rdata = 0.
  - addr[1:0] is ignored.
- Latency: rvalid_o[p] and rdata_o[p] are asserted exactly RESP_LATENCY cycles after the grant edge, for one cycle. Responses stay in order. rvalid has no backpressure.
  - rdata_o holds its last value when rvalid_o=0.
- Outstanding counter: +1 on grant, -1 on retire, unchanged when both happen in the same cycle. It never exceeds MAX_OUTSTANDING and never underflows.
- Address decode:
  - addr < 2^RAM_ADDR_WIDTH selects RAM.
  - Write to STATUS_ADDR: wdata == 32'd123456789 sets tests_passed_o; wdata == 32'd1 sets tests_failed_o; any other value is ignored.
  - Write to EXIT_ADDR sets exit_valid_o and captures exit_value_o = wdata. Later writes to EXIT_ADDR update exit_value_o.
  - Status and exit flags are sticky until reset.
  - Any other address: reads return 0, writes are dropped. A response is still produced.
- Same-cycle collisions:
  - Two ports write the same word: per byte, the highest-index port with that be bit set wins.
  - Read and write of the same word in the same cycle on different ports: the read returns the pre-write data.
  - Two ports write EXIT_ADDR in the same cycle: the highest-index port's data is captured.
- Reset mid-operation: all in-flight responses are discarded and no rvalid is produced for them. Memory writes already performed remain.

Test Plan:
- RESP_LATENCY=3, STALL_MODE=0: port 0 writes 32'hDEADBEEF to 0x100 with be=4'hF, then reads 0x100 -> rvalid 3 cycles after each grant; read returns 32'hDEADBEEF.
- MAX_OUTSTANDING=2, RESP_LATENCY=4: port 1 holds req for 6 cycles -> gnt high for 2 cycles, then low until the first retire. Counter sequence 1,2,2,...; never 3.
- Byte enables: write 32'h11223344 with be=4'hF, then 32'hAABBCCDD with be=4'b0101, then read -> 32'h11BB33DD.
- Collision: port 0 and port 1 both write 0x200 with be=4'hF, data 32'h0 and 32'hFFFFFFFF -> read returns 32'hFFFFFFFF. A same-cycle read of 0x200 on port 2 returns the prior contents.
- Pseudo peripherals: write 123456789 to STATUS_ADDR -> tests_passed_o=1, tests_failed_o=0. Write 32'h2A to EXIT_ADDR -> exit_valid_o=1, exit_value_o=32'h2A. Read of 0x3000_0000 returns 0.
- STALL_MODE=1: continuous req for 1000 cycles on port 0 -> grant count between 700 and 800 and deterministic for seed 16'hACE1. Asserting rst_ni=0 with 2 reads in flight yields no rvalid after reset release.
